riscv_run_controller: RTL

RISCV_RUN_CONTROLLER -- requirements
Module: riscv_run_controller

---
 rtl/riscv_run_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/riscv_run_controller.sv
// Run controller for a core under test: holds the core in reset, lets it run,
// and grades the run once the result bus settles or the cycle budget runs out.
module riscv_run_controller #(
    parameter int RESULT_W      = 16,
    parameter int RST_CYCLES    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 100,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [RESULT_W-1:0] result,
    input  logic [RESULT_W-1:0] expected,
    output logic                cpu_rst_n,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycles,
    output logic [RESULT_W-1:0] final_result
);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {IDLE, RESET_CPU, RUN, PASS, FAIL} state_e;

    state_e              state_q, state_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [STAB_W-1:0]   stab_q, stab_d, stab_inc;
    logic [CNT_W-1:0]    cycles_q, cycles_d, cycles_inc;
    logic [RESULT_W-1:0] prev_q, prev_d, final_q, final_d;
    logic                cpu_rst_n_q, cpu_rst_n_d, done_q, done_d;
    logic                pass_q, pass_d, timeout_q, timeout_d;
    logic                stable, timeout_hit;

    // cycles is cleared on every start, so zero in RUN marks the first RUN cycle
    always_comb begin
        cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
        if (cycles_q == '0 || result != prev_q) stab_inc = STAB_ONE;
        else                                    stab_inc = stab_q + 1'b1;
        stable      = (stab_inc == STAB_DONE);
        timeout_hit = (cycles_inc >= CNT_TO);
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stab_d      = stab_q;
        cycles_d    = cycles_q;
        prev_d      = prev_q;
        final_d     = final_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        if (abort) begin
            state_d     = IDLE;
            cpu_rst_n_d = 1'b0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, PASS, FAIL: if (start) begin
                    state_d     = RESET_CPU;
                    rst_cnt_d   = '0;
                    stab_d      = '0;
                    cycles_d    = '0;
                    final_d     = '0;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
                RESET_CPU: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d     = RUN;
                        rst_cnt_d   = '0;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cycles_d = cycles_inc;
                    prev_d   = result;
                    stab_d   = stab_inc;
                    // stability is tested first so it wins a tie with the timeout
                    if (stable || timeout_hit) begin
                        final_d     = result;
                        cpu_rst_n_d = 1'b0;
                        done_d      = 1'b1;
                        pass_d      = stable && (result == expected);
                        timeout_d   = !stable;
                        state_d     = (stable && result == expected) ? PASS : FAIL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rst_cnt_q   <= '0;
            stab_q      <= '0;
            cycles_q    <= '0;
            prev_q      <= '0;
            final_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stab_q      <= stab_d;
            cycles_q    <= cycles_d;
            prev_q      <= prev_d;
            final_q     <= final_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_rst_n    = cpu_rst_n_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign cycles       = cycles_q;
    assign final_result = final_q;
endmodule
